// File: rtl/hamming_rd_sched.sv
// rtl/hamming_rd_sched.sv - two-requester read scheduler for the four-bank Hamming memory (option: HAMMING_RD_SCHED_FIXED_PRIO_EN)
module hamming_rd_sched #(
    parameter int ADDR_WIDTH   = 6,
    parameter int ADDR_1       = 5,
    parameter int ADDR_2       = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic                  i_req_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic                  i_stall,
    output logic                  o_gnt_a,
    output logic                  o_gnt_b,
    output logic [3:0]            o_bank_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [1:0]            o_sel,
    output logic                  o_rvalid,
    output logic                  o_rid
);

    localparam int RL      = READ_LATENCY;
    localparam int BANK_LO = ADDR_2 - 1;

    logic                  grant_ok;
    logic                  gnt_a;
    logic                  gnt_b;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [1:0]            gnt_bank;

    logic [3:0]            bank_en_q, bank_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  iss_valid_q, iss_valid_d;
    logic                  iss_id_q, iss_id_d;
    logic [1:0]            iss_bank_q, iss_bank_d;

    // Tracker entries; index RL-1 is the oldest and drives the return outputs.
    logic [RL-1:0]         trk_valid_q, trk_valid_d;
    logic [RL-1:0]         trk_id_q, trk_id_d;
    logic [2*RL-1:0]       trk_bank_q, trk_bank_d;

    // Reset and a pending write both block new grants.
    assign grant_ok = ~i_stall & ~i_rst;

`ifdef HAMMING_RD_SCHED_FIXED_PRIO_EN
    // A always wins contention.
    assign gnt_a = grant_ok & i_req_a;
    assign gnt_b = grant_ok & i_req_b & ~i_req_a;
`else
    logic prio_b_q, prio_b_d;

    // Round-robin: contention goes to the requester not granted most recently.
    assign gnt_a = grant_ok & i_req_a & (~i_req_b | ~prio_b_q);
    assign gnt_b = grant_ok & i_req_b & (~i_req_a | prio_b_q);

    // Every grant hands priority to the other requester.
    always_comb begin
        prio_b_d = prio_b_q;
        if (gnt_a) begin
            prio_b_d = 1'b1;
        end else if (gnt_b) begin
            prio_b_d = 1'b0;
        end
    end

    // Priority pointer register; reset favours A.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end
`endif

    assign o_gnt_a  = gnt_a;
    assign o_gnt_b  = gnt_b;
    assign gnt_addr = gnt_b ? i_addr_b : i_addr_a;
    assign gnt_bank = gnt_addr[ADDR_1-1:BANK_LO];

    // Issue stage: one-hot bank enable for the granted read; address holds when idle.
    always_comb begin
        iss_valid_d = gnt_a | gnt_b;
        iss_id_d    = gnt_b;
        iss_bank_d  = gnt_bank;
        bank_en_d   = 4'b0000;
        addr_d      = addr_q;
        if (iss_valid_d) begin
            bank_en_d = 4'b0001 << gnt_bank;
            addr_d    = gnt_addr;
        end
    end

    // Tracker shifts every cycle; the oldest slot keeps id/bank when nothing valid arrives
    // so the mux select holds its last value.
    always_comb begin
        trk_valid_d = (trk_valid_q << 1) | RL'(iss_valid_q);
        trk_id_d    = (trk_id_q << 1) | RL'(iss_id_q);
        trk_bank_d  = (trk_bank_q << 2) | (2*RL)'(iss_bank_q);
        if (!trk_valid_d[RL-1]) begin
            trk_id_d[RL-1]          = trk_id_q[RL-1];
            trk_bank_d[2*RL-1 -: 2] = trk_bank_q[2*RL-1 -: 2];
        end
    end

    // Issue and tracker registers; reset discards every in-flight read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_en_q   <= '0;
            addr_q      <= '0;
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_bank_q  <= '0;
            trk_valid_q <= '0;
            trk_id_q    <= '0;
            trk_bank_q  <= '0;
        end else begin
            bank_en_q   <= bank_en_d;
            addr_q      <= addr_d;
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_bank_q  <= iss_bank_d;
            trk_valid_q <= trk_valid_d;
            trk_id_q    <= trk_id_d;
            trk_bank_q  <= trk_bank_d;
        end
    end

    assign o_bank_en = bank_en_q;
    assign o_addr    = addr_q;
    assign o_rvalid  = trk_valid_q[RL-1];
    assign o_rid     = trk_id_q[RL-1];
    assign o_sel     = trk_bank_q[2*RL-1 -: 2];

endmodule

// File: tb/tb_hamming_rd_sched.sv
// tb/tb_hamming_rd_sched.sv - scoreboard bench for hamming_rd_sched
module tb_hamming_rd_sched;

    parameter int RL = 2;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [5:0] addr;
    } iss_t;

    typedef struct {
        int         cyc;
        logic       id;
        logic [1:0] sel;
    } ret_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, stall;
    logic [5:0] addr_a, addr_b;
    logic       o_gnt_a, o_gnt_b, o_rvalid, o_rid;
    logic [3:0] o_bank_en;
    logic [5:0] o_addr;
    logic [1:0] o_sel;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    iss_t iss_q[$];
    ret_t ret_q[$];
    logic [1:0] last_sel = 2'b00;

    hamming_rd_sched #(
        .ADDR_WIDTH  (6),
        .ADDR_1      (5),
        .ADDR_2      (4),
        .READ_LATENCY(RL)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req_a  (req_a),
        .i_addr_a (addr_a),
        .i_req_b  (req_b),
        .i_addr_b (addr_b),
        .i_stall  (stall),
        .o_gnt_a  (o_gnt_a),
        .o_gnt_b  (o_gnt_b),
        .o_bank_en(o_bank_en),
        .o_addr   (o_addr),
        .o_sel    (o_sel),
        .o_rvalid (o_rvalid),
        .o_rid    (o_rid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; grants are checked here, responses are queued for the monitor.
    task automatic step(input logic ra, input logic [5:0] aa, input logic rb,
                        input logic [5:0] ab, input logic st, input logic rs,
                        input logic ega, input logic egb, input logic [1:0] ebank);
        iss_t ie;
        ret_t re;
        @(posedge clk);
        #1;
        req_a  = ra;
        addr_a = aa;
        req_b  = rb;
        addr_b = ab;
        stall  = st;
        rst    = rs;
        if (rs) begin
            iss_q.delete();
            ret_q.delete();
            last_sel = 2'b00;
        end
        @(negedge clk);
        chk("gnt_a", int'(o_gnt_a), int'(ega));
        chk("gnt_b", int'(o_gnt_b), int'(egb));
        if (rs) begin
            chk("rst_bank_en", int'(o_bank_en), 0);
            chk("rst_addr", int'(o_addr), 0);
            chk("rst_sel", int'(o_sel), 0);
            chk("rst_rvalid", int'(o_rvalid), 0);
            chk("rst_rid", int'(o_rid), 0);
        end
        if (ega || egb) begin
            ie.cyc  = cyc + 1;
            ie.en   = 4'b0001 << ebank;
            ie.addr = ega ? aa : ab;
            iss_q.push_back(ie);
            re.cyc  = cyc + 1 + RL;
            re.id   = egb;
            re.sel  = ebank;
            ret_q.push_back(re);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an issue or a return.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (o_bank_en != 4'b0000) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", int'(o_bank_en), 0);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("issue_cycle", cyc, e.cyc);
                    chk("bank_en", int'(o_bank_en), int'(e.en));
                    chk("addr", int'(o_addr), int'(e.addr));
                end
            end
            if (o_rvalid) begin
                if (ret_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    ret_t r;
                    r = ret_q.pop_front();
                    chk("ret_cycle", cyc, r.cyc);
                    chk("rid", int'(o_rid), int'(r.id));
                    chk("sel", int'(o_sel), int'(r.sel));
                    last_sel = r.sel;
                end
            end else begin
                chk("sel_hold", int'(o_sel), int'(last_sel));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        stall  = 1'b0;
        addr_a = 6'd0;
        addr_b = 6'd0;

        // Reset state with A requesting: no grant, all outputs zero.
        step(1'b1, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        // Contention: A bank0, B bank3.
`ifdef HAMMING_RD_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            step(1'b1, 6'b000000, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
`else
        step(1'b1, 6'b000000, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 6'b000000, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        step(1'b1, 6'b000000, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 6'b000000, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
`endif
        step(1'b0, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Single A read, bank 2.
        step(1'b1, 6'b010011, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Back-to-back A reads across all four banks.
        step(1'b1, 6'b000101, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 6'b001000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 6'b010000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        step(1'b1, 6'b011111, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);

        // Stall with one read in flight and B pending.
        step(1'b1, 6'b001010, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'b000000, 1'b1, 6'b110100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 6'b000000, 1'b1, 6'b110100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);

        // Two reads in flight, one-cycle reset pulse, then an immediate A grant.
        step(1'b1, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b0, 6'b000000, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        step(1'b1, 6'b010011, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 6'b010011, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);

        // Drain; every expected response must have been seen.
        for (int i = 0; i < RL + 6; i++)
            step(1'b0, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("issue_queue_left", iss_q.size(), 0);
        chk("return_queue_left", ret_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_rd_sched.md
# hamming_rd_sched

Read scheduler for the four-bank Hamming-encoded memory. It arbitrates two read requesters onto the shared bank read path and issues one-hot bank enables plus the in-bank address. It tracks each in-flight read for READ_LATENCY cycles, then drives the select of the bank-output 4:1 mux with the matching bank index and flags which requester owns the returned word. It sits between the requester ports and the bank array / output mux.

## Interface
- ADDR_WIDTH, 6, full read address width
- ADDR_1, 5, bank-select field upper bound; field is address bits [ADDR_1-1:ADDR_2-1]
- ADDR_2, 4, bank-select field lower bound; field is exactly 2 bits (ADDR_1-ADDR_2+1 == 2)
- READ_LATENCY, 2, cycles from bank enable to bank data valid; legal range 1..8

- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req_a  in  1  requester A read request, held until granted
- i_addr_a  in  ADDR_WIDTH  requester A address, stable while i_req_a high
- i_req_b  in  1  requester B read request, held until granted
- i_addr_b  in  ADDR_WIDTH  requester B address
- i_stall  in  1  blocks new grants (write in progress)
- o_gnt_a  out  1  combinational grant to A
- o_gnt_b  out  1  combinational grant to B
- o_bank_en  out  4  registered one-hot bank read enable
- o_addr  out  ADDR_WIDTH  registered address to banks
- o_sel  out  2  registered mux select, [1:0] = bank index
- o_rvalid  out  1  returned word on mux output is valid this cycle
- o_rid  out  1  owner of returned word: 0 = A, 1 = B

## Operation
- Grant: no grant while i_stall=1 or i_rst=1. Only one requester active -> grant it. Both active -> round-robin (default); grant the requester not granted most recently.
- RR pointer: updates on every grant to favour the other requester; reset value favours A.
- At most one grant per cycle; o_gnt_a and o_gnt_b are never high together.
- Issue stage: the grant in cycle T registers at T+1 as o_bank_en = one-hot of granted address bank field, o_addr = granted address; o_bank_en=0 when there is no grant. o_addr holds its previous value when idle.
- Tracking: shift register of READ_LATENCY entries {valid, id, bank}, loaded from the issue stage, advancing every cycle and never stalled. i_stall does not affect in-flight reads.
- Return: the last entry drives o_rvalid, o_rid and o_sel. o_sel holds its last value when o_rvalid=0.
- Throughput: one read per cycle; back-to-back grants to the same or different banks are allowed, and returns are in issue order.
- Bank field decode: address bits [ADDR_1-1:ADDR_2-1] give 00->bank0 ... 11->bank3.

## Timing
- Grant at T -> o_bank_en/o_addr at T+1 -> o_rvalid/o_sel/o_rid at T+1+READ_LATENCY.
- READ_LATENCY=2: request at cycle 0 returns at cycle 3.
- Reset values (async, immediate): o_bank_en=0, o_addr=0, o_sel=0, o_rvalid=0, o_rid=0, all tracker entries invalid, RR pointer favours A. o_gnt_* are forced 0 while i_rst=1.
- Reset mid-operation: all in-flight reads are discarded and no o_rvalid is asserted for them. The first grant is possible in the first cycle after i_rst deasserts.
- Request deasserted without grant: legal, no side effect.
- i_stall rising in the same cycle as a request: no grant that cycle, and the request stays pending.

## Configuration
- HAMMING_RD_SCHED_FIXED_PRIO_EN defined: fixed priority, A always wins contention; RR pointer logic removed.
- Undefined (default): round-robin as above.

## Test plan
- Single A read at addr 6'b010011, READ_LATENCY=2 -> o_gnt_a at T; o_bank_en=4'b0100 and o_addr=6'b010011 at T+1; o_rvalid=1, o_sel=2'b10, o_rid=0 at T+3.
- A and B requesting continuously, round-robin -> grants alternate A,B,A,B starting with A after reset; four consecutive o_rvalid cycles with o_rid 0,1,0,1. With HAMMING_RD_SCHED_FIXED_PRIO_EN defined, A is granted every cycle and B is starved.
- Back-to-back A reads to banks 0,1,2,3 -> o_bank_en 0001,0010,0100,1000 on consecutive cycles; o_sel 0,1,2,3 on consecutive return cycles.
- i_stall=1 for 3 cycles with B pending and one read in flight -> the in-flight read still returns on schedule; B is granted in the cycle i_stall falls.
- i_rst pulsed for 1 cycle with 2 reads in flight -> no o_rvalid for either read; all outputs 0 during reset; the next A request is granted in the first cycle after reset deasserts.
- READ_LATENCY=1 and READ_LATENCY=8 builds -> return occurs exactly at T+2 and T+9 respectively.
